// File: rtl/set_pkg.sv
// Shared types and widths for the SET job dispatcher and its job FIFO.
package set_pkg;

  localparam int unsigned CENTRAL_W = 24;
  localparam int unsigned RADIUS_W  = 12;
  localparam int unsigned CAND_W    = 8;
  localparam int unsigned MODE_W    = 2;
  // Widest tag a queued job can carry; instances use the low TAG_W bits.
  localparam int unsigned TAG_MAX_W = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_A     = 2'd0,
    MODE_UNION = 2'd1,
    MODE_DIFF  = 2'd2,
    MODE_INTER = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } state_e;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    mode_e                mode;
    logic [TAG_MAX_W-1:0] tag;
  } job_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/set_job_fifo.sv
// Job FIFO feeding the SET dispatcher. DEPTH must be a power of two so the
// pointers wrap naturally.
module set_job_fifo
  import set_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  job_t push_data,
  input  logic pop,
  output job_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  job_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/set_dispatch.sv
// Dispatcher in front of the SET circle-counting engine: queues jobs, issues
// them one at a time, returns results in order. Optional watchdog under
// SET_DISPATCH_TIMEOUT_EN.
module set_dispatch
  import set_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CENTRAL_W-1:0] in_central,
  input  logic [RADIUS_W-1:0]  in_radius,
  input  logic [MODE_W-1:0]    in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [MODE_W-1:0]    set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CAND_W-1:0]    out_candidate,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err,
  output logic [15:0]          done_cnt
);

  state_e           state_q;
  job_t             push_job;
  job_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue;
  logic [TAG_W-1:0] cur_tag_q;
  logic             unused_tag_bits;

  assign push_job = '{central: in_central, radius: in_radius, mode: mode_e'(in_mode),
                      tag: TAG_MAX_W'(in_tag)};
  assign in_ready = !fifo_full;
  assign issue    = (state_q == StIdle) && !fifo_empty && !set_busy;
  assign unused_tag_bits = ^head.tag;

  set_job_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .push_data(push_job),
    .pop      (issue),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef SET_DISPATCH_TIMEOUT_EN
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              err_q;
  logic              timed_out;
  assign timed_out = (wait_cnt_q == WCNT_W'(TIMEOUT - 1));
  assign out_err   = err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      cur_tag_q     <= '0;
      out_valid     <= 1'b0;
      out_candidate <= '0;
      out_tag       <= '0;
      done_cnt      <= '0;
`ifdef SET_DISPATCH_TIMEOUT_EN
      wait_cnt_q    <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      set_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            state_q     <= StIssue;
            set_en      <= 1'b1;
            set_central <= head.central;
            set_radius  <= head.radius;
            set_mode    <= head.mode;
            cur_tag_q   <= head.tag[TAG_W-1:0];
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef SET_DISPATCH_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        StWait: begin
          // A result on the expiry cycle takes priority over the watchdog.
          if (set_valid) begin
            state_q       <= StHold;
            out_valid     <= 1'b1;
            out_candidate <= set_candidate;
            out_tag       <= cur_tag_q;
            done_cnt      <= sat_inc16(done_cnt);
`ifdef SET_DISPATCH_TIMEOUT_EN
            err_q         <= 1'b0;
          end else if (timed_out) begin
            state_q       <= StHold;
            out_valid     <= 1'b1;
            out_candidate <= '0;
            out_tag       <= cur_tag_q;
            done_cnt      <= sat_inc16(done_cnt);
            err_q         <= 1'b1;
          end else begin
            wait_cnt_q    <= wait_cnt_q + WCNT_W'(1);
`endif
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_set_dispatch.sv
// Directed bench for set_dispatch with a small behavioural SET engine model.
// Timeout scenario runs only when SET_DISPATCH_TIMEOUT_EN is defined.
module tb_set_dispatch;

  localparam int unsigned TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [23:0]      in_central = '0;
  logic [11:0]      in_radius = '0;
  logic [1:0]       in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             set_en;
  logic [23:0]      set_central;
  logic [11:0]      set_radius;
  logic [1:0]       set_mode;
  logic             set_busy;
  logic             set_valid = 1'b0;
  logic [7:0]       set_candidate = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_candidate;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [15:0]      done_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int en_count = 0;

  // Engine model state
  int   eng_lat = 10;
  int   eng_override = -1;
  int   eng_cnt = 0;
  bit   eng_mute = 1'b0;
  bit   force_busy = 1'b0;
  logic eng_busy = 1'b0;

  assign set_busy = eng_busy | force_busy;

  set_dispatch #(
    .DEPTH  (4),
    .TAG_W  (TAG_W),
    .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_central   (in_central),
    .in_radius    (in_radius),
    .in_mode      (in_mode),
    .in_tag       (in_tag),
    .set_en       (set_en),
    .set_central  (set_central),
    .set_radius   (set_radius),
    .set_mode     (set_mode),
    .set_busy     (set_busy),
    .set_valid    (set_valid),
    .set_candidate(set_candidate),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_candidate(out_candidate),
    .out_tag      (out_tag),
    .out_err      (out_err),
    .done_cnt     (done_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (set_en === 1'b1) en_count++;

  // Engine: busy after a start pulse, one-cycle valid after eng_lat cycles.
  // Result defaults to central[7:0] + mode unless overridden.
  always @(negedge clk) begin
    set_valid = 1'b0;
    if (!rst_n) begin
      eng_busy = 1'b0;
      eng_cnt  = 0;
    end else if (set_en === 1'b1 && !eng_mute) begin
      eng_busy = 1'b1;
      eng_cnt  = eng_lat;
    end else if (eng_busy) begin
      eng_cnt--;
      if (eng_cnt <= 0) begin
        eng_busy      = 1'b0;
        set_valid     = 1'b1;
        set_candidate = (eng_override >= 0) ? eng_override[7:0]
                                            : set_central[7:0] + {6'b0, set_mode};
      end
    end
  end

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_eq(name, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (set_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_eq(name, 32'(set_en), 32'd1);
  endtask

  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                          input logic [TAG_W-1:0] t);
    int n = 0;
    in_valid   = 1'b1;
    in_central = c;
    in_radius  = r;
    in_mode    = m;
    in_tag     = t;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) check_eq("push_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [5];
    int         e0;
    bit         ok;

    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_set_en", 32'(set_en), 32'd0);
    check_eq("rst_set_central", 32'(set_central), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
    check_eq("rst_out_err", 32'(out_err), 32'd0);
    check_eq("rst_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Single job
    eng_override = 29;
    eng_lat      = 10;
    in_valid     = 1'b1;
    in_central   = 24'h334455;
    in_radius    = 12'h333;
    in_mode      = 2'd0;
    in_tag       = 6'd5;
    tick();
    in_valid = 1'b0;
    check_eq("t1_en_at_push", 32'(set_en), 32'd0);
    tick();
    check_eq("t1_en_high", 32'(set_en), 32'd1);
    check_eq("t1_central", 32'(set_central), 32'h334455);
    check_eq("t1_radius", 32'(set_radius), 32'h333);
    check_eq("t1_mode", 32'(set_mode), 32'd0);
    tick();
    check_eq("t1_en_low", 32'(set_en), 32'd0);
    wait_out("t1_out_valid");
    check_eq("t1_cand", 32'(out_candidate), 32'd29);
    check_eq("t1_tag", 32'(out_tag), 32'd5);
    check_eq("t1_err", 32'(out_err), 32'd0);
    check_eq("t1_done", 32'(done_cnt), 32'd1);
    tick();
    check_eq("t1_out_drop", 32'(out_valid), 32'd0);

    // Queue fill: one in flight plus four queued
    eng_override = -1;
    eng_lat      = 8;
    for (int i = 0; i < 5; i++) begin
      exp_q[i] = 8'(i * 7 + 3) + 8'(i % 4);
      push_job({16'h0, 8'(i * 7 + 3)}, 12'h111, 2'(i % 4), TAG_W'(i));
    end
    check_eq("t2_full", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      wait_out($sformatf("t2_valid%0d", k));
      check_eq($sformatf("t2_tag%0d", k), 32'(out_tag), 32'(k));
      check_eq($sformatf("t2_cand%0d", k), 32'(out_candidate), 32'(exp_q[k]));
      tick();
    end
    check_eq("t2_done", 32'(done_cnt), 32'd6);
    check_eq("t2_ready_again", 32'(in_ready), 32'd1);

    // Busy gating
    force_busy = 1'b1;
    push_job(24'h123456, 12'h0ab, 2'd3, 6'd9);
    e0 = en_count;
    repeat (30) tick();
    check_eq("t3_no_en_busy", 32'(en_count), 32'(e0));
    force_busy = 1'b0;
    check_eq("t3_en_before", 32'(set_en), 32'd0);
    tick();
    check_eq("t3_en_after", 32'(set_en), 32'd1);
    wait_out("t3_out_valid");
    check_eq("t3_tag", 32'(out_tag), 32'd9);
    check_eq("t3_cand", 32'(out_candidate), 32'h59);
    tick();

    // Backpressure
    out_ready = 1'b0;
    push_job(24'h000021, 12'h222, 2'd1, 6'd20);
    push_job(24'h000030, 12'h222, 2'd2, 6'd21);
    wait_out("t4_out_valid");
    e0 = en_count;
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b1 || out_candidate !== 8'h22 || out_tag !== 6'd20) ok = 1'b0;
    end
    check_eq("t4_stable", 32'(ok), 32'd1);
    check_eq("t4_no_issue", 32'(en_count), 32'(e0));
    check_eq("t4_cand", 32'(out_candidate), 32'h22);
    out_ready = 1'b1;
    tick();
    check_eq("t4_drop", 32'(out_valid), 32'd0);
    wait_out("t4_second");
    check_eq("t4_tag2", 32'(out_tag), 32'd21);
    check_eq("t4_cand2", 32'(out_candidate), 32'h32);
    tick();

`ifdef SET_DISPATCH_TIMEOUT_EN
    // Watchdog expiry, then a normal job
    eng_mute = 1'b1;
    push_job(24'h000040, 12'h001, 2'd0, 6'd33);
    wait_en("t5_en");
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check_eq("t5_quiet", 32'(ok), 32'd1);
    tick();
    check_eq("t5_valid", 32'(out_valid), 32'd1);
    check_eq("t5_err", 32'(out_err), 32'd1);
    check_eq("t5_cand", 32'(out_candidate), 32'd0);
    check_eq("t5_tag", 32'(out_tag), 32'd33);
    tick();
    eng_mute = 1'b0;
    push_job(24'h000044, 12'h001, 2'd1, 6'd34);
    wait_out("t5_next_valid");
    check_eq("t5_next_err", 32'(out_err), 32'd0);
    check_eq("t5_next_tag", 32'(out_tag), 32'd34);
    check_eq("t5_next_cand", 32'(out_candidate), 32'h45);
    tick();
`endif

    // Mid-job reset with two jobs queued
    eng_lat = 40;
    push_job(24'h000001, 12'h001, 2'd0, 6'd40);
    push_job(24'h000002, 12'h001, 2'd0, 6'd41);
    push_job(24'h000003, 12'h001, 2'd0, 6'd42);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_set_en", 32'(set_en), 32'd0);
    check_eq("t6_central", 32'(set_central), 32'd0);
    check_eq("t6_radius", 32'(set_radius), 32'd0);
    check_eq("t6_mode", 32'(set_mode), 32'd0);
    check_eq("t6_out_valid", 32'(out_valid), 32'd0);
    check_eq("t6_cand", 32'(out_candidate), 32'd0);
    check_eq("t6_tag", 32'(out_tag), 32'd0);
    check_eq("t6_err", 32'(out_err), 32'd0);
    check_eq("t6_done", 32'(done_cnt), 32'd0);
    check_eq("t6_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    e0 = en_count;
    repeat (20) tick();
    check_eq("t6_no_en", 32'(en_count), 32'(e0));
    eng_lat = 5;
    push_job(24'h000050, 12'h001, 2'd3, 6'd43);
    wait_out("t6_new_valid");
    check_eq("t6_new_tag", 32'(out_tag), 32'd43);
    check_eq("t6_new_cand", 32'(out_candidate), 32'h53);
    check_eq("t6_new_done", 32'(done_cnt), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
